// File: rtl/demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Optional feature macro used by stream_demux: DEMUX_BCAST_EN (broadcast).
package demux_pkg;

    // One-entry slot occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;

    // True when a select value addresses an existing channel
    function automatic logic sel_valid(input logic [31:0] sel, input logic [31:0] channels);
        return (sel < channels);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice for a single demux output channel.
// Holds one word; free when empty or when draining this cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    slot_state_t      state_r;
    logic [WIDTH-1:0] data_r;

    // Occupancy and stored word; a load wins over a drain so there is no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
            data_r  <= {WIDTH{1'b0}};
        end else if (load) begin
            state_r <= FULL;
            data_r  <= load_data;
        end else if ((state_r == FULL) && ready) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_r;
        end
    end

    assign valid = (state_r == FULL);
    assign data  = data_r;
    assign free  = (state_r == EMPTY) || ready;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-channel back-pressure.
// Optional broadcast mode is enabled by defining DEMUX_BCAST_EN; without it
// the in_bcast port is present but ignored.
module stream_demux
    import demux_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_bcast,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      sel_err
);

    logic [CHANNELS-1:0] free_s;
    logic [CHANNELS-1:0] load_s;
    logic                in_range_s;
    logic                bcast_s;
    logic                in_ready_s;
    logic                xfer_s;
    logic                sel_err_r;

`ifdef DEMUX_BCAST_EN
    assign bcast_s = in_bcast;
`else
    logic bcast_unused_s;
    assign bcast_unused_s = in_bcast;
    assign bcast_s        = 1'b0;
`endif

    assign in_range_s = sel_valid({{(32-SEL_W){1'b0}}, in_sel}, 32'(CHANNELS));

    // Acceptance: broadcast needs every slot free, out-of-range words are always taken
    always_comb begin
        in_ready_s = 1'b1;
        if (bcast_s) begin
            in_ready_s = &free_s;
        end else if (in_range_s) begin
            in_ready_s = free_s[in_sel];
        end else begin
            in_ready_s = 1'b1;
        end
    end

    assign in_ready = in_ready_s;
    assign xfer_s   = in_valid && in_ready_s;

    // One slot per channel; each loads when addressed (or broadcast) on a transfer
    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        assign load_s[k] = xfer_s && (bcast_s || (in_range_s && (in_sel == SEL_W'(k))));

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_s[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*WIDTH +: WIDTH]),
            .free      (free_s[k])
        );
    end

    // Flag an accepted word whose select addresses no channel, one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= xfer_s && !in_range_s && !bcast_s;
        end
    end

    assign sel_err = sel_err_r;

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux: a 4-channel instance for
// steering, back-pressure and drain/load, and a 3-channel instance for
// out-of-range selects. Broadcast checks follow DEMUX_BCAST_EN.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        in_bcast;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        sel_err;

    // 3-channel instance
    logic [7:0]  in_data3;
    logic [1:0]  in_sel3;
    logic        in_valid3;
    logic        in_ready3;
    logic [23:0] out_data3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic        sel_err3;

    int total = 0;
    int bad   = 0;

    stream_demux #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcast  (in_bcast),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    stream_demux #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_bcast  (1'b0),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sel_err   (sel_err3)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock, then settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_sel     = 2'd2;
        in_valid   = 1'b0;
        in_bcast   = 1'b0;
        out_ready  = 4'b0000;
        in_data3   = 8'h00;
        in_sel3    = 2'd0;
        in_valid3  = 1'b0;
        out_ready3 = 3'b000;

        // reset held for three cycles
        repeat (3) step();
        check_val("rst_valid_during", 64'(out_valid), 64'h0);
        rst_n = 1'b1;
        #1;
        check_val("rst_valid", 64'(out_valid), 64'h0);
        check_val("rst_data", 64'(out_data), 64'h0);
        check_val("rst_sel_err", 64'(sel_err), 64'h0);
        check_val("rst_in_ready", 64'(in_ready), 64'h1);
        check_val("rst_valid3", 64'(out_valid3), 64'h0);

        // steering 0xA5 to channel 2
        out_ready = 4'b1111;
        in_sel    = 2'd2;
        in_data   = 8'hA5;
        in_valid  = 1'b1;
        #1;
        check_val("steer_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        check_val("steer_valid", 64'(out_valid), 64'h4);
        check_val("steer_data", 64'(out_data[23:16]), 64'hA5);
        step();
        check_val("steer_clear", 64'(out_valid), 64'h0);
        check_val("steer_hold", 64'(out_data[23:16]), 64'hA5);

        // back-pressure on channel 1
        out_ready = 4'b1101;
        in_sel    = 2'd1;
        in_data   = 8'h11;
        in_valid  = 1'b1;
        #1;
        check_val("bp_first_ready", 64'(in_ready), 64'h1);
        step();
        in_data = 8'h12;
        #1;
        check_val("bp_second_ready", 64'(in_ready), 64'h0);
        step();
        check_val("bp_hold_valid", 64'(out_valid), 64'h2);
        check_val("bp_hold_data", 64'(out_data[15:8]), 64'h11);
        in_sel  = 2'd3;
        in_data = 8'h33;
        #1;
        check_val("bp_other_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        check_val("bp_other_valid", 64'(out_valid), 64'hA);
        check_val("bp_other_data", 64'(out_data[31:24]), 64'h33);
        step();
        check_val("bp_ch3_drained", 64'(out_valid), 64'h2);
        out_ready = 4'b1111;
        step();
        check_val("bp_ch1_drained", 64'(out_valid), 64'h0);
        check_val("bp_ch1_keep", 64'(out_data[15:8]), 64'h11);
        in_sel   = 2'd1;
        in_data  = 8'h12;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_val("bp_retry_valid", 64'(out_valid), 64'h2);
        check_val("bp_retry_data", 64'(out_data[15:8]), 64'h12);
        step();

        // simultaneous drain and load on channel 0
        out_ready = 4'b0000;
        in_sel    = 2'd0;
        in_data   = 8'h22;
        in_valid  = 1'b1;
        step();
        check_val("dl_first_valid", 64'(out_valid), 64'h1);
        check_val("dl_first_data", 64'(out_data[7:0]), 64'h22);
        out_ready = 4'b0001;
        in_data   = 8'h33;
        #1;
        check_val("dl_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        check_val("dl_valid", 64'(out_valid), 64'h1);
        check_val("dl_data", 64'(out_data[7:0]), 64'h33);
        step();
        check_val("dl_drained", 64'(out_valid), 64'h0);

        // out-of-range select on the 3-channel instance
        in_sel3   = 2'd3;
        in_data3  = 8'h77;
        in_valid3 = 1'b1;
        #1;
        check_val("oor_ready", 64'(in_ready3), 64'h1);
        step();
        in_valid3 = 1'b0;
        check_val("oor_err_pulse", 64'(sel_err3), 64'h1);
        check_val("oor_valid", 64'(out_valid3), 64'h0);
        step();
        check_val("oor_err_clear", 64'(sel_err3), 64'h0);
        check_val("oor_valid_still", 64'(out_valid3), 64'h0);
        in_sel3   = 2'd2;
        in_data3  = 8'h44;
        in_valid3 = 1'b1;
        step();
        in_valid3 = 1'b0;
        check_val("ch3_inrange_valid", 64'(out_valid3), 64'h4);
        check_val("ch3_inrange_data", 64'(out_data3[23:16]), 64'h44);
        check_val("ch3_inrange_err", 64'(sel_err3), 64'h0);

`ifdef DEMUX_BCAST_EN
        // broadcast to all free slots
        out_ready = 4'b1111;
        in_bcast  = 1'b1;
        in_sel    = 2'd3;
        in_data   = 8'h5A;
        in_valid  = 1'b1;
        #1;
        check_val("bc_ready", 64'(in_ready), 64'h1);
        step();
        in_valid  = 1'b0;
        out_ready = 4'b1011;
        check_val("bc_valid", 64'(out_valid), 64'hF);
        check_val("bc_data", 64'(out_data), 64'h5A5A5A5A);
        step();
        check_val("bc_ch2_full", 64'(out_valid), 64'h4);
        in_data  = 8'h6B;
        in_valid = 1'b1;
        #1;
        check_val("bc_blocked", 64'(in_ready), 64'h0);
        step();
        check_val("bc_blocked_again", 64'(in_ready), 64'h0);
        check_val("bc_blocked_valid", 64'(out_valid), 64'h4);
        out_ready = 4'b1111;
        #1;
        check_val("bc_unblocked", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        check_val("bc2_valid", 64'(out_valid), 64'hF);
        check_val("bc2_data", 64'(out_data), 64'h6B6B6B6B);
        check_val("bc2_no_err", 64'(sel_err), 64'h0);
        step();
`else
        // in_bcast ignored: only the selected channel loads
        out_ready = 4'b1111;
        in_bcast  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 8'h5A;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        check_val("nobc_valid", 64'(out_valid), 64'h2);
        check_val("nobc_data", 64'(out_data[15:8]), 64'h5A);
        step();
`endif

        // reset while a channel holds a word
        out_ready = 4'b0000;
        in_sel    = 2'd3;
        in_data   = 8'hC3;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        check_val("mid_loaded", 64'(out_valid), 64'h8);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(out_valid), 64'h0);
        check_val("mid_rst_data", 64'(out_data), 64'h0);
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
